blob_bbox: RTL and testbench

//  Consumes the binary pixel stream produced by the threshold stage and measures one frame's foreground object.
//  Per frame it finds the bounding box (x_min/x_max/y_min/y_max) and the foreground pixel count.

---
 rtl/blob_bbox.sv | 134 +++++++++++++
 tb/tb_blob_bbox.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/blob_bbox.sv
// ============================================================================
// Module   : blob_bbox
// Purpose  : Per-frame bounding box and foreground pixel count of a binary
//            (thresholded) pixel stream, published once per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blob_bbox #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int CW       = 19,
  parameter int MIN_PIX  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sof,
  input  logic          pix_valid,
  input  logic [15:0]   thr_in,
  output logic          box_valid,
  output logic          box_found,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] pix_count,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_PIX);

  logic [1:0]    state, state_nxt;
  logic [XW-1:0] x_cnt, acc_xmin, acc_xmax, px;
  logic [YW-1:0] y_cnt, acc_ymin, acc_ymax, py;
  logic [CW-1:0] acc_cnt;
  logic          fg, start, take, x_wrap, last, found;
  logic          unused_bits;

  assign unused_bits = ^thr_in[15:8];
  assign fg          = |thr_in[7:0];
  // A sof pixel is accepted in every state; plain pixels only while accumulating.
  assign start  = pix_valid && sof;
  assign take   = start || (pix_valid && state == S_ACCUM);
  assign px     = start ? '0 : x_cnt;
  assign py     = start ? '0 : y_cnt;
  assign x_wrap = (px == X_LAST);
  assign last   = take && x_wrap && (py == Y_LAST);
  assign found  = (acc_cnt >= CNT_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = last ? S_DONE : S_ACCUM;
      S_ACCUM: if (take) state_nxt = last ? S_DONE : S_ACCUM;
      S_DONE: begin
        state_nxt = S_IDLE;
        if (take) state_nxt = last ? S_DONE : S_ACCUM;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ACCUM);
  end

  // Position tracking and accumulation of the frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      acc_cnt  <= '0;
      acc_xmin <= '0;
      acc_xmax <= '0;
      acc_ymin <= '0;
      acc_ymax <= '0;
    end else if (take) begin
      x_cnt <= x_wrap ? '0 : px + XW'(1);
      y_cnt <= x_wrap ? ((py == Y_LAST) ? '0 : py + YW'(1)) : py;
      if (start) begin
        acc_cnt  <= {{(CW-1){1'b0}}, fg};
        acc_xmin <= fg ? '0 : '1;
        acc_ymin <= fg ? '0 : '1;
        acc_xmax <= '0;
        acc_ymax <= '0;
      end else if (fg) begin
        if (acc_cnt != '1) acc_cnt <= acc_cnt + CW'(1);
        if (px < acc_xmin) acc_xmin <= px;
        if (px > acc_xmax) acc_xmax <= px;
        if (py < acc_ymin) acc_ymin <= py;
        if (py > acc_ymax) acc_ymax <= py;
      end
    end
  end

  // Publish on the DONE cycle; the accumulators may be re-seeded on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      box_valid <= 1'b0;
      box_found <= 1'b0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      pix_count <= '0;
    end else begin
      box_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        box_found <= found;
        pix_count <= acc_cnt;
        x_min     <= found ? acc_xmin : '0;
        x_max     <= found ? acc_xmax : '0;
        y_min     <= found ? acc_ymin : '0;
        y_max     <= found ? acc_ymax : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blob_bbox.sv
// ============================================================================
// Module   : tb_blob_bbox
// Purpose  : Directed, table-driven bench for blob_bbox on an 8x4 frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_blob_bbox;

  localparam int NPIX = 32;

  logic        clk = 1'b0;
  logic        reset, sof, pix_valid;
  logic [15:0] thr_in;
  logic        box_valid, box_found, busy;
  logic [9:0]  x_min, x_max, y_min, y_max;
  logic [18:0] pix_count;

  blob_bbox #(.H_ACTIVE(8), .V_ACTIVE(4), .XW(10), .YW(10), .CW(19), .MIN_PIX(4)) dut (
    .clk(clk), .reset(reset), .sof(sof), .pix_valid(pix_valid), .thr_in(thr_in),
    .box_valid(box_valid), .box_found(box_found), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .pix_count(pix_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    logic [15:0] fg_val;
    logic [15:0] bg_val;
    bit          gaps;
    int          found, xmin, xmax, ymin, ymax, cnt;
  } vec_t;

  typedef struct {
    int found, xmin, xmax, ymin, ymax, cnt;
  } snap_t;

  vec_t  vecs[7];
  snap_t caps[64];
  int    pulses = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;

  always @(posedge clk) begin
    #1;
    if (box_valid === 1'b1) begin
      if (pulses < 64) begin
        caps[pulses].found = int'(box_found);
        caps[pulses].xmin  = int'(x_min);
        caps[pulses].xmax  = int'(x_max);
        caps[pulses].ymin  = int'(y_min);
        caps[pulses].ymax  = int'(y_max);
        caps[pulses].cnt   = int'(pix_count);
      end
      pulses++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input int k, input vec_t v);
    if (k < 0 || k >= 64) begin
      chk({tag, "_idx"}, 32'(k), 32'(0));
    end else begin
      chk({tag, "_found"}, 32'(caps[k].found), 32'(v.found));
      chk({tag, "_xmin"},  32'(caps[k].xmin),  32'(v.xmin));
      chk({tag, "_xmax"},  32'(caps[k].xmax),  32'(v.xmax));
      chk({tag, "_ymin"},  32'(caps[k].ymin),  32'(v.ymin));
      chk({tag, "_ymax"},  32'(caps[k].ymax),  32'(v.ymax));
      chk({tag, "_count"}, 32'(caps[k].cnt),   32'(v.cnt));
    end
  endtask

  // Sends n pixels in raster order, the first one carrying sof.
  task automatic send_pixels(input logic [31:0] mask, input logic [15:0] fgv,
                             input logic [15:0] bgv, input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          @(negedge clk);
          pix_valid = 1'b0;
          sof       = 1'b0;
          thr_in    = 16'h00FF;
        end
      end
      @(negedge clk);
      pix_valid = 1'b1;
      sof       = (i == 0);
      thr_in    = mask[i] ? fgv : bgv;
    end
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int p0;
    p0 = pulses;
    send_pixels(v.mask, v.fg_val, v.bg_val, v.gaps, NPIX);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    chk({tag, "_bv_early"}, 32'(box_valid), 32'(0));
    @(negedge clk);
    chk({tag, "_bv_pulse"}, 32'(box_valid), 32'(1));
    chk({tag, "_npulse"}, 32'(pulses - p0), 32'(1));
    chk_snap(tag, pulses - 1, v);
    @(negedge clk);
    chk({tag, "_bv_end"}, 32'(box_valid), 32'(0));
  endtask

  initial begin
    int p0;
    reset = 1'b1; sof = 1'b0; pix_valid = 1'b0; thr_in = 16'h0000;

    vecs[0] = '{mask:32'h003C3C00, fg_val:16'h00FF, bg_val:16'h0000, gaps:1'b0,
                found:1, xmin:2, xmax:5, ymin:1, ymax:2, cnt:8};
    vecs[1] = '{mask:32'h00000000, fg_val:16'h00FF, bg_val:16'h0000, gaps:1'b0,
                found:0, xmin:0, xmax:0, ymin:0, ymax:0, cnt:0};
    vecs[2] = '{mask:32'h80100001, fg_val:16'h00FF, bg_val:16'h0000, gaps:1'b0,
                found:0, xmin:0, xmax:0, ymin:0, ymax:0, cnt:3};
    vecs[3] = '{mask:32'h00000000, fg_val:16'h00FF, bg_val:16'hFF00, gaps:1'b0,
                found:0, xmin:0, xmax:0, ymin:0, ymax:0, cnt:0};
    vecs[4] = '{mask:32'h003C3C00, fg_val:16'h00FF, bg_val:16'h0000, gaps:1'b1,
                found:1, xmin:2, xmax:5, ymin:1, ymax:2, cnt:8};
    vecs[5] = '{mask:32'h08010042, fg_val:16'h8001, bg_val:16'hFF00, gaps:1'b0,
                found:1, xmin:0, xmax:6, ymin:0, ymax:3, cnt:4};
    vecs[6] = '{mask:32'hFFFFFFFF, fg_val:16'h0080, bg_val:16'h0000, gaps:1'b0,
                found:1, xmin:0, xmax:7, ymin:0, ymax:3, cnt:32};

    repeat (3) @(negedge clk);
    chk("rst_bv",    32'(box_valid), 32'(0));
    chk("rst_found", 32'(box_found), 32'(0));
    chk("rst_xmax",  32'(x_max),     32'(0));
    chk("rst_count", 32'(pix_count), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].gaps ? 6 : 1) @(negedge clk);
      run_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Aborted frame: sof re-asserted after 10 pixels.
    p0 = pulses;
    send_pixels(32'hFFFFFFFF, 16'h00FF, 16'h0000, 1'b0, 10);
    @(negedge clk);
    pix_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'(1));
    run_frame("abort", vecs[0]);
    chk("abort_total", 32'(pulses - p0), 32'(1));

    // Back-to-back: second frame's sof lands on the DONE cycle.
    p0 = pulses;
    send_pixels(vecs[0].mask, 16'h00FF, 16'h0000, 1'b0, NPIX);
    send_pixels(vecs[2].mask, 16'h00FF, 16'h0000, 1'b0, NPIX);
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    chk("b2b_npulse", 32'(pulses - p0), 32'(2));
    chk_snap("b2b_a", p0, vecs[0]);
    chk_snap("b2b_b", p0 + 1, vecs[2]);
    @(negedge clk);

    // Reset mid-frame after a publish.
    run_frame("pre_rst", vecs[6]);
    send_pixels(vecs[0].mask, 16'h00FF, 16'h0000, 1'b0, 10);
    #2 reset = 1'b1;
    #1;
    chk("mrst_found", 32'(box_found), 32'(0));
    chk("mrst_xmax",  32'(x_max),     32'(0));
    chk("mrst_ymax",  32'(y_max),     32'(0));
    chk("mrst_count", 32'(pix_count), 32'(0));
    chk("mrst_busy",  32'(busy),      32'(0));
    @(negedge clk);
    reset = 1'b0;
    pix_valid = 1'b0;
    p0 = pulses;
    for (int i = 0; i < NPIX + 2; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      sof       = 1'b0;
      thr_in    = 16'h00FF;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("nosof_npulse", 32'(pulses - p0), 32'(0));
    chk("nosof_busy",   32'(busy),        32'(0));
    run_frame("post_rst", vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

`default_nettype wire
